// File: rtl/uart_transmitter.sv
// UART transmitter: 16x-oversampled bit timing, 8 data bits sent LSB first, one stop bit.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_transmitter #(
  parameter int unsigned CLK_FREQ = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       Tx_D,
  output logic       Tx_BUSY
);

  // The divisor table below assumes a 100 MHz clock; CLK_FREQ only records that.
  if (CLK_FREQ == 0) begin : g_clk_freq_check
    $error("CLK_FREQ must be nonzero");
  end

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  baud_q, baud_d;
  logic [7:0]  data_q, data_d;
  logic [14:0] div_q, div_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;

  logic [14:0] div_max;
  logic        tick;
  logic        bit_done;
  logic        write_ok;

  // Terminal count is divisor - 1 so one tick spans exactly `divisor` clocks.
  always_comb begin
    div_max = 15'd53;
    unique case (baud_q)
      3'd0: div_max = 15'd20832;
      3'd1: div_max = 15'd5207;
      3'd2: div_max = 15'd1301;
      3'd3: div_max = 15'd650;
      3'd4: div_max = 15'd325;
      3'd5: div_max = 15'd162;
      3'd6: div_max = 15'd108;
      3'd7: div_max = 15'd53;
      default: div_max = 15'd53;
    endcase
  end

  assign tick     = (div_q == div_max);
  assign bit_done = tick && (tick_q == 4'd15);
  assign write_ok = Tx_WR && Tx_EN && !busy_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    data_d  = data_q;
    div_d   = div_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    if (state_q == StIdle) begin
      // Counters are parked in idle so every frame starts on a fresh bit boundary.
      div_d  = 15'd0;
      tick_d = 4'd0;
      tx_d   = 1'b1;
      if (write_ok) begin
        state_d = StStart;
        data_d  = Tx_DATA;
        baud_d  = baud_select;
        bit_d   = 3'd0;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
      end
    end else begin
      div_d = tick ? 15'd0 : div_q + 15'd1;
      if (tick) begin
        tick_d = tick_q + 4'd1;
      end
      if (bit_done) begin
        unique case (state_q)
          StStart: begin
            state_d = StData;
            bit_d   = 3'd0;
            tx_d    = data_q[0];
          end
          StData: begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = StParity;
              tx_d    = ^data_q;
`else
              state_d = StStop;
              tx_d    = 1'b1;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
              tx_d  = data_q[bit_q + 3'd1];
            end
          end
          StParity: begin
            state_d = StStop;
            tx_d    = 1'b1;
          end
          StStop: begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
          default: begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= 3'd0;
      data_q  <= 8'd0;
      div_q   <= 15'd0;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      data_q  <= data_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign Tx_D    = tx_q;
  assign Tx_BUSY = busy_q;

endmodule
